// File: rtl/fetch_pkg.sv
// Shared definitions for the IF-stage fetch sequencer: redirect select
// encodings, FSM state type, NOP encoding and default address width.
package fetch_pkg;

    localparam int ADDR_W_DEF = 16;

    // Redirect select values presented by decode on pc_src.
    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_J   = 2'd1;
    localparam logic [1:0] PC_SRC_I   = 2'd2;
    localparam logic [1:0] PC_SRC_RET = 2'd3;

    // Instruction substituted into IF when kill is asserted (addi x0,x0,0).
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_t;

    // 16-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        sat_inc16 = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_ras.sv
// Circular return-address stack. Push when full overwrites the oldest
// entry; pop when empty is ignored. Overflow/underflow are single-cycle
// pulses, the owner decides whether to make them sticky.
module return_addr_stack #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] push_data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign empty_o     = (cnt_q == '0);
    assign full_o      = (cnt_q == FULL_CNT);
    assign top_o       = mem_q[ptr_q];
    assign overflow_o  = push_i & full_o;
    assign underflow_o = pop_i & empty_o;

    // Next top pointer and occupancy; push wins if both are ever raised.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_q + 1'b1;
            if (!full_o) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop_i && !empty_o) begin
            ptr_d = ptr_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[ptr_d] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage program counter sequencer: sequential step, stall hold,
// J/I/return redirects with a one-cycle squash of the wrong-path fetch,
// and a return-address stack for calls/returns.
//
// Timing contract: a redirect presented in cycle N is accepted at the
// rising edge ending N; in N+1 pc holds the target and kill is high.
// Decode keeps pc_src, targets and call stable while stall_req is high;
// nothing is latched during a stall.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_req,
    input  logic [1:0]        pc_src,
    input  logic              call,
    input  logic [ADDR_W-1:0] j_target,
    input  logic [ADDR_W-1:0] i_target,
    input  logic [ADDR_W-1:0] ret_addr_in,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic              kill,
    output logic              ras_overflow,
    output logic              ras_underflow,
    output logic [15:0]       redirect_cnt,
    output logic [1:0]        dbg_state,
    output logic              dbg_ras_empty,
    output logic              dbg_ras_full
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic              kill_q, kill_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              ras_push, ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty, ras_full;
    logic              ras_ovf_pulse, ras_unf_pulse;

    return_addr_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset       (reset),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (npc_q),
        .top_o       (ras_top),
        .empty_o     (ras_empty),
        .full_o      (ras_full),
        .overflow_o  (ras_ovf_pulse),
        .underflow_o (ras_unf_pulse)
    );

    // Next-state / next-pc selection; stall beats everything, the KILL
    // cycle ignores decode because the ID instruction is wrong-path.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        kill_d   = kill_q;
        cnt_d    = cnt_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;

        if (stall_req) begin
            state_d = (state_q == ST_KILL) ? ST_KILL : ST_STALL;
            kill_d  = (state_q == ST_KILL);
        end else if (state_q == ST_KILL) begin
            pc_d    = pc_q + 1'b1;
            state_d = ST_RUN;
            kill_d  = 1'b0;
        end else if (pc_src == PC_SRC_SEQ) begin
            pc_d    = pc_q + 1'b1;
            state_d = ST_RUN;
            kill_d  = 1'b0;
        end else begin
            state_d = ST_KILL;
            kill_d  = 1'b1;
            cnt_d   = sat_inc16(cnt_q);
            case (pc_src)
                PC_SRC_J: begin
                    pc_d     = j_target;
                    ras_push = call;
                end
                PC_SRC_I: begin
                    pc_d = i_target;
                end
                default: begin
                    ras_pop = 1'b1;
                    pc_d    = ras_empty ? ret_addr_in : ras_top;
                end
            endcase
        end
    end

    assign npc_d = pc_d + 1'b1;
    assign ovf_d = ovf_q | ras_ovf_pulse;
    assign unf_d = unf_q | ras_unf_pulse;

    // FSM and all registered outputs; synchronous reset has top priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            npc_q   <= RESET_PC + 1'b1;
            kill_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            kill_q  <= kill_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc            = pc_q;
    assign npc           = npc_q;
    assign kill          = kill_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign redirect_cnt  = cnt_q;
    assign dbg_state     = state_q;
    assign dbg_ras_empty = ras_empty;
    assign dbg_ras_full  = ras_full;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Each vector drives one cycle of
// inputs at the falling edge and queues the hand-computed outputs expected
// after the next rising edge; a monitor pops and compares just after it.
module tb_fetch_sequencer;

  localparam int W = 54;
  localparam logic [1:0] RUN = 2'd0, STL = 2'd1, KIL = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_req = 1'b0;
  logic [1:0]  pc_src = 2'd0;
  logic        call = 1'b0;
  logic [15:0] j_target = '0, i_target = '0, ret_addr_in = '0;
  logic [15:0] pc, npc, redirect_cnt;
  logic        kill, ras_overflow, ras_underflow;
  logic [1:0]  dbg_state;
  logic        dbg_ras_empty, dbg_ras_full;

  logic [W-1:0] exp_q[$];
  int           id_q[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           vec_id = 0;

  fetch_sequencer #(.ADDR_W(16), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall_req     (stall_req),
    .pc_src        (pc_src),
    .call          (call),
    .j_target      (j_target),
    .i_target      (i_target),
    .ret_addr_in   (ret_addr_in),
    .pc            (pc),
    .npc           (npc),
    .kill          (kill),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow),
    .redirect_cnt  (redirect_cnt),
    .dbg_state     (dbg_state),
    .dbg_ras_empty (dbg_ras_empty),
    .dbg_ras_full  (dbg_ras_full)
  );

  // clock
  always #5 clk = ~clk;

  // driver: one cycle of inputs plus the outputs expected after the edge
  task automatic step(
    input logic r, input logic s, input logic [1:0] src, input logic c,
    input logic [15:0] jt, input logic [15:0] it, input logic [15:0] ra,
    input logic [15:0] ep, input logic ek, input logic eo, input logic eu,
    input logic [15:0] ec, input logic [1:0] es, input logic ee);
    logic [15:0] enpc;
    @(negedge clk);
    reset = r; stall_req = s; pc_src = src; call = c;
    j_target = jt; i_target = it; ret_addr_in = ra;
    enpc = ep + 16'd1;
    exp_q.push_back({ep, enpc, ek, eo, eu, ec, es, ee});
    id_q.push_back(vec_id);
    vec_id++;
  endtask

  // monitor / scoreboard
  initial begin
    logic [W-1:0] got, exp;
    int id;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        id = id_q.pop_front();
        got = {pc, npc, kill, ras_overflow, ras_underflow, redirect_cnt, dbg_state, dbg_ras_empty};
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL vec%0d: got pc=%h npc=%h kill=%b ovf=%b unf=%b cnt=%0d st=%0d empty=%b; exp pc=%h npc=%h kill=%b ovf=%b unf=%b cnt=%0d st=%0d empty=%b",
                   id, got[53:38], got[37:22], got[21], got[20], got[19], got[18:3], got[2:1], got[0],
                   exp[53:38], exp[37:22], exp[21], exp[20], exp[19], exp[18:3], exp[2:1], exp[0]);
        end
      end
    end
  end

  // stimulus
  initial begin
    // reset, then free run 1..5
    step(1,0,0,0, 0,0,0, 16'h0000,0,0,0, 0,RUN,1);
    for (int i = 1; i <= 5; i++)
      step(0,0,0,0, 0,0,0, 16'(i),0,0,0, 0,RUN,1);
    // stall at pc=5 with I-type redirect held, then release
    for (int i = 0; i < 3; i++)
      step(0,1,2,0, 0,16'h0040,0, 16'h0005,0,0,0, 0,STL,1);
    step(0,0,2,0, 0,16'h0040,0, 16'h0040,1,0,0, 1,KIL,1);
    step(0,0,0,0, 0,0,0,        16'h0041,0,0,0, 1,RUN,1);
    // get to pc=0x10, call to 0x100, return to 0x11
    step(0,0,2,0, 0,16'h000F,0, 16'h000F,1,0,0, 2,KIL,1);
    step(0,0,0,0, 0,0,0,        16'h0010,0,0,0, 2,RUN,1);
    step(0,0,1,1, 16'h0100,0,0, 16'h0100,1,0,0, 3,KIL,0);
    step(0,0,0,0, 0,0,0,        16'h0101,0,0,0, 3,RUN,0);
    step(0,0,3,0, 0,0,0,        16'h0011,1,0,0, 4,KIL,1);
    step(0,0,0,0, 0,0,0,        16'h0012,0,0,0, 4,RUN,1);
    // return with empty RAS -> fallback address, sticky underflow
    step(0,0,3,0, 0,0,16'h002A, 16'h002A,1,0,1, 5,KIL,1);
    step(0,0,0,0, 0,0,0,        16'h002B,0,0,1, 5,RUN,1);
    step(0,0,0,0, 0,0,0,        16'h002C,0,0,1, 5,RUN,1);
    // redirect during KILL is ignored (no push either)
    step(0,0,2,0, 0,16'h0080,0, 16'h0080,1,0,1, 6,KIL,1);
    step(0,0,1,1, 16'h0200,0,0, 16'h0081,0,0,1, 6,RUN,1);
    // reset during KILL with stall held
    step(0,0,2,0, 0,16'h0090,0, 16'h0090,1,0,1, 7,KIL,1);
    step(1,1,2,0, 0,16'h0090,0, 16'h0000,0,0,0, 0,RUN,1);
    // five calls into a 4-deep RAS; stall inside the first KILL
    step(0,0,1,1, 16'h0300,0,0, 16'h0300,1,0,0, 1,KIL,0);
    step(0,1,3,0, 0,0,0,        16'h0300,1,0,0, 1,KIL,0);
    step(0,0,0,0, 0,0,0,        16'h0301,0,0,0, 1,RUN,0);
    step(0,0,1,1, 16'h0400,0,0, 16'h0400,1,0,0, 2,KIL,0);
    step(0,0,0,0, 0,0,0,        16'h0401,0,0,0, 2,RUN,0);
    step(0,0,1,1, 16'h0500,0,0, 16'h0500,1,0,0, 3,KIL,0);
    step(0,0,0,0, 0,0,0,        16'h0501,0,0,0, 3,RUN,0);
    step(0,0,1,1, 16'h0600,0,0, 16'h0600,1,0,0, 4,KIL,0);
    step(0,0,0,0, 0,0,0,        16'h0601,0,0,0, 4,RUN,0);
    step(0,0,1,1, 16'h0700,0,0, 16'h0700,1,1,0, 5,KIL,0);
    step(0,0,0,0, 0,0,0,        16'h0701,0,1,0, 5,RUN,0);
    // four returns: E, D, C, B
    step(0,0,3,0, 0,0,0,        16'h0602,1,1,0, 6,KIL,0);
    step(0,0,0,0, 0,0,0,        16'h0603,0,1,0, 6,RUN,0);
    step(0,0,3,0, 0,0,0,        16'h0502,1,1,0, 7,KIL,0);
    step(0,0,0,0, 0,0,0,        16'h0503,0,1,0, 7,RUN,0);
    step(0,0,3,0, 0,0,0,        16'h0402,1,1,0, 8,KIL,0);
    step(0,0,0,0, 0,0,0,        16'h0403,0,1,0, 8,RUN,0);
    step(0,0,3,0, 0,0,0,        16'h0302,1,1,0, 9,KIL,1);
    step(0,0,0,0, 0,0,0,        16'h0303,0,1,0, 9,RUN,1);
    // fifth return underflows to the fallback address
    step(0,0,3,0, 0,0,16'h0055, 16'h0055,1,1,1, 10,KIL,1);
    step(0,0,0,0, 0,0,0,        16'h0056,0,1,1, 10,RUN,1);
    // npc wrap at the top of the address space
    step(0,0,2,0, 0,16'hFFFF,0, 16'hFFFF,1,1,1, 11,KIL,1);
    step(0,0,0,0, 0,0,0,        16'h0000,0,1,1, 11,RUN,1);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
